npc_ras: RTL and testbench

NPC_RAS -- requirements
Module: npc_ras

---
 rtl/npc_ras.sv | 155 +++++++++++++++
 tb/tb_npc_ras.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/npc_ras.sv
// npc_ras: next-fetch-PC select; F_PC registered (1 cycle); stall holds F_PC, hazards surface via jr_wait.
// Return-address stack, pending mispredict redirect and flush_F exist only when NPC_RAS_EN is defined.
module npc_ras #(
    parameter logic [31:0] RESET_PC   = 32'h00003000,
    parameter logic [31:0] EXC_VECTOR = 32'h00004180,
    parameter logic [31:0] IM_LO      = 32'h00003000,
    parameter logic [31:0] IM_HI      = 32'h00006FFC,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] F_PC,
    output logic        F_AdEL,
    output logic        flush_F,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_ra,
    input  logic        D_ra_ready,
    input  logic [2:0]  nPC_Sel,
    input  logic        D_bjump,
    input  logic        D_is_jal,
    input  logic        D_is_jr_ra,
    output logic        ras_used,
    output logic [31:0] ras_target,
    output logic        jr_wait,
    input  logic        E_jr_pred,
    input  logic [31:0] E_pred_target,
    input  logic [31:0] E_ra,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] EPC
);
    logic [31:0] f_pc_q;
    logic [31:0] npc;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] ras_top;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        ras_hit;
    logic        jr_sel;

    assign pc4       = f_pc_q + 32'd4;
    assign br_target = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign jr_sel    = (nPC_Sel == 3'd3);

`ifdef NPC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = RAS_DEPTH[PW:0];

    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_ptr;
    logic [PW:0]   ras_cnt;
    logic          pend_vld;
    logic [31:0]   pend_pc;
    logic          ras_empty;
    logic          push_en;
    logic          pop_en;
    logic          mis;

    // ras_ptr is the next free slot; the top lives one below it (wraps circularly).
    assign ras_empty   = (ras_cnt == '0);
    assign ras_top     = ras_mem[ras_ptr - PTR_ONE];
    assign ras_hit     = jr_sel && !D_ra_ready && D_is_jr_ra && !ras_empty;
    assign mis         = E_jr_pred && (E_ra != E_pred_target);
    assign redirect    = !stall && !exc_req && !eret && (mis || pend_vld);
    assign redirect_pc = mis ? E_ra : pend_pc;
    assign push_en     = D_is_jal && !stall && !exc_req;
    assign pop_en      = D_is_jr_ra && !stall && !exc_req && !ras_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (push_en && !pop_en) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            if (ras_cnt != CNT_FULL)
                ras_cnt <= ras_cnt + CNT_ONE;
        end else if (pop_en && !push_en) begin
            ras_ptr <= ras_ptr - PTR_ONE;
            ras_cnt <= ras_cnt - CNT_ONE;
        end
    end

    // Simultaneous pop+push replaces the top in place.
    always_ff @(posedge clk) begin
        if (!reset && push_en)
            ras_mem[pop_en ? (ras_ptr - PTR_ONE) : ras_ptr] <= D_PC + 32'd8;
    end

    always_ff @(posedge clk) begin
        if (reset || exc_req || eret) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else if (stall && mis) begin
            pend_vld <= 1'b1;
            pend_pc  <= E_ra;
        end else if (!stall) begin
            pend_vld <= 1'b0;
        end
    end

    assign ras_used   = ras_hit;
    assign ras_target = ras_hit ? ras_top : 32'h0;
    assign flush_F    = redirect;
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{E_jr_pred, E_pred_target, E_ra, D_is_jal, D_is_jr_ra};
    assign ras_hit     = 1'b0;
    assign ras_top     = 32'h0;
    assign redirect    = 1'b0;
    assign redirect_pc = 32'h0;
    assign ras_used    = 1'b0;
    assign ras_target  = 32'h0;
    assign flush_F     = 1'b0;
`endif

    assign jr_wait = jr_sel && !D_ra_ready && !ras_hit;

    always_comb begin
        npc = pc4;
        if (exc_req)
            npc = EXC_VECTOR;
        else if (eret)
            npc = EPC;
        else if (redirect)
            npc = redirect_pc;
        else if (stall)
            npc = f_pc_q;
        else begin
            case (nPC_Sel)
                3'd0:    npc = pc4;
                3'd1:    npc = D_bjump ? br_target : pc4;
                3'd2:    npc = {D_PC[31:28], D_imm26, 2'b00};
                3'd3:    npc = D_ra_ready ? D_ra : (ras_hit ? ras_top : pc4);
                default: npc = RESET_PC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            f_pc_q <= RESET_PC;
        else
            f_pc_q <= npc;
    end

    assign F_PC   = f_pc_q;
    assign F_AdEL = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);

endmodule

// File: tb/tb_npc_ras.sv
// Scoreboard bench for npc_ras: a queue/array reference model predicts each cycle's outputs.
module tb_npc_ras;
    localparam logic [31:0] RESET_PC = 32'h00003000;
    localparam logic [31:0] EXC_VEC  = 32'h00004180;
    localparam logic [31:0] IM_LO    = 32'h00003000;
    localparam logic [31:0] IM_HI    = 32'h00006FFC;
    localparam int          DEPTH    = 4;
`ifdef NPC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, D_ra_ready, D_bjump, D_is_jal, D_is_jr_ra;
    logic        E_jr_pred, exc_req, eret;
    logic [31:0] D_PC, D_ra, E_pred_target, E_ra, EPC;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [2:0]  nPC_Sel;
    logic [31:0] F_PC, ras_target;
    logic        F_AdEL, flush_F, ras_used, jr_wait;

    npc_ras dut (
        .clk(clk), .reset(reset), .stall(stall), .F_PC(F_PC), .F_AdEL(F_AdEL), .flush_F(flush_F),
        .D_PC(D_PC), .D_imm16(D_imm16), .D_imm26(D_imm26), .D_ra(D_ra), .D_ra_ready(D_ra_ready),
        .nPC_Sel(nPC_Sel), .D_bjump(D_bjump), .D_is_jal(D_is_jal), .D_is_jr_ra(D_is_jr_ra),
        .ras_used(ras_used), .ras_target(ras_target), .jr_wait(jr_wait),
        .E_jr_pred(E_jr_pred), .E_pred_target(E_pred_target), .E_ra(E_ra),
        .exc_req(exc_req), .eret(eret), .EPC(EPC)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        adel;
        logic        flush;
        logic        used;
        logic [31:0] tgt;
        logic        jrw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] stk[$];
    logic [31:0] m_pc, m_pend_pc;
    logic        m_pend;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("F_PC", F_PC, e.pc);
            chk("F_AdEL", {31'b0, F_AdEL}, {31'b0, e.adel});
            chk("flush_F", {31'b0, flush_F}, {31'b0, e.flush});
            chk("ras_used", {31'b0, ras_used}, {31'b0, e.used});
            chk("ras_target", ras_target, e.tgt);
            chk("jr_wait", {31'b0, jr_wait}, {31'b0, e.jrw});
        end
    end

    task automatic idle();
        stall = 0; nPC_Sel = 0; D_PC = 0; D_imm16 = 0; D_imm26 = 0; D_ra = 0;
        D_ra_ready = 0; D_bjump = 0; D_is_jal = 0; D_is_jr_ra = 0;
        E_jr_pred = 0; E_pred_target = 0; E_ra = 0; exc_req = 0; eret = 0; EPC = 0;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
    task automatic step();
        exp_t        e;
        logic        mis, redir, hit;
        logic [31:0] top, npc, pc4;
        if (reset) begin
            m_pc = RESET_PC; m_pend = 0; m_pend_pc = 0; stk.delete();
        end else begin
            pc4   = m_pc + 32'd4;
            mis   = RAS_EN && E_jr_pred && (E_ra != E_pred_target);
            redir = RAS_EN && !stall && !exc_req && !eret && (mis || m_pend);
            hit   = RAS_EN && nPC_Sel == 3 && !D_ra_ready && D_is_jr_ra && stk.size() > 0;
            top   = (stk.size() > 0) ? stk[$] : 32'h0;
            e.pc    = m_pc;
            e.adel  = (m_pc % 4 != 0) || (m_pc < IM_LO) || (m_pc > IM_HI);
            e.flush = redir;
            e.used  = hit;
            e.tgt   = hit ? top : 32'h0;
            e.jrw   = (nPC_Sel == 3) && !D_ra_ready && !hit;
            sb.push_back(e);

            if (exc_req)     npc = EXC_VEC;
            else if (eret)   npc = EPC;
            else if (redir)  npc = mis ? E_ra : m_pend_pc;
            else if (stall)  npc = m_pc;
            else if (nPC_Sel == 0) npc = pc4;
            else if (nPC_Sel == 1) npc = D_bjump ? D_PC + 32'd4 + 32'(int'($signed(D_imm16)) * 4) : pc4;
            else if (nPC_Sel == 2) npc = (D_PC & 32'hF000_0000) | (32'(D_imm26) << 2);
            else if (nPC_Sel == 3) npc = D_ra_ready ? D_ra : (hit ? top : pc4);
            else                   npc = RESET_PC;

            if (exc_req || eret) m_pend = 0;
            else if (stall && mis) begin m_pend = 1; m_pend_pc = E_ra; end
            else if (!stall) m_pend = 0;

            if (RAS_EN && !stall && !exc_req) begin
                if (D_is_jr_ra && stk.size() > 0) void'(stk.pop_back());
                if (D_is_jal) begin
                    stk.push_back(D_PC + 32'd8);
                    if (stk.size() > DEPTH) void'(stk.pop_front());
                end
            end
            m_pc = npc;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        step(); step();
        reset = 0;

        // Reset state and free-running fetch
        chk("rst_F_PC", F_PC, 32'h3000);
        chk("rst_flush_F", {31'b0, flush_F}, 32'h0);
        chk("rst_ras_used", {31'b0, ras_used}, 32'h0);
        chk("rst_F_AdEL", {31'b0, F_AdEL}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("free_F_PC", F_PC, 32'h3000 + 32'(4 * i));
        end

        // Backward branch taken, then not taken from 0x3014
        nPC_Sel = 1; D_bjump = 1; D_PC = 32'h3010; D_imm16 = 16'hFFFC;
        step();
        chk("br_taken", F_PC, 32'h3004);
        idle(); nPC_Sel = 3; D_ra_ready = 1; D_ra = 32'h3014;
        step();
        chk("jr_ready", F_PC, 32'h3014);
        idle(); nPC_Sel = 1; D_bjump = 0; D_PC = 32'h3010; D_imm16 = 16'hFFFC;
        step();
        chk("br_not_taken", F_PC, 32'h3018);

        // jal push, predicted jr $ra, correct E check
        idle(); nPC_Sel = 2; D_is_jal = 1; D_PC = 32'h3020; D_imm26 = 26'h0C10;
        step();
        idle(); step();
        nPC_Sel = 3; D_is_jr_ra = 1; D_PC = 32'h3040;
        step();
        idle(); E_jr_pred = 1; E_pred_target = 32'h3028; E_ra = 32'h3028;
        step();

        // Mispredict under stall becomes pending, applied on first free cycle
        idle(); stall = 1; E_jr_pred = 1; E_pred_target = 32'h3028; E_ra = 32'h3100;
        step();
        idle(); stall = 1;
        step();
        idle();
        step();
        step();

        // Overflow the stack then drain it with predicted pops
        for (int i = 0; i < 5; i++) begin
            idle(); nPC_Sel = 0; D_is_jal = 1; D_PC = 32'h3200 + 32'(16 * i);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            idle(); nPC_Sel = 3; D_is_jr_ra = 1; D_PC = 32'h3300;
            step();
        end

        // Exception during stall, then eret to a misaligned EPC
        idle(); exc_req = 1; stall = 1;
        step();
        chk("exc_F_PC", F_PC, 32'h4180);
        idle(); eret = 1; EPC = 32'h3002;
        step();
        chk("eret_F_PC", F_PC, 32'h3002);
        chk("eret_F_AdEL", {31'b0, F_AdEL}, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            nPC_Sel       = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            D_PC          = 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            D_imm16       = 16'($urandom);
            D_imm26       = 26'($urandom);
            D_ra          = 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            D_ra_ready    = $urandom_range(0, 1) == 1;
            D_bjump       = $urandom_range(0, 1) == 1;
            D_is_jal      = ($urandom_range(0, 3) == 0);
            D_is_jr_ra    = ($urandom_range(0, 2) == 0);
            E_jr_pred     = ($urandom_range(0, 3) == 0);
            E_ra          = 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            E_pred_target = ($urandom_range(0, 1) == 1) ? E_ra : 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            exc_req       = ($urandom_range(0, 29) == 0);
            eret          = ($urandom_range(0, 29) == 0);
            EPC           = $urandom;
            step();
        end
        reset = 0;
        idle();

        @(negedge clk); @(negedge clk);
        chk("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
